nios_sys_seg7_scan: RTL and testbench
=====================================

NIOS_SYS_SEG7_SCAN -- requirements
Module: nios_sys_seg7_scan

Interface
REQ-001 Parameter PRESCALE_INIT, default 16'd999, SHALL be the reset value of the PRESCALE register.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 address  input  2  SHALL be the Avalon-MM word address: 0 DATA, 1 CTRL, 2 PRESCALE, 3 STATUS.
REQ-005 chipselect  input  1  SHALL qualify the slave access.
REQ-006 write_n  input  1  SHALL be the active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-007 writedata  input  32  SHALL be the write data.
REQ-008 readdata  output  32  SHALL be the combinational read data, zero-wait, unused bits 0.
REQ-009 seg_n  output  7  SHALL be the active-low segments, bit0=a through bit6=g.
REQ-010 dp_n  output  1  SHALL be the active-low decimal point.
REQ-011 dig_n  output  4  SHALL be the active-low digit enables, bit0=digit 0.

Function
REQ-012 DATA[15:0] SHALL hold one hex nibble per digit, digit k at [4k+3:4k]; bits [31:16] SHALL read 0.
REQ-013 CTRL SHALL hold: [0] enable, [7:4] decimal point per digit, [11:8] blank mask per digit; other bits SHALL read 0.
REQ-014 PRESCALE[15:0] SHALL set the digit period to PRESCALE+1 clocks; a write SHALL take effect at the next counter reload.
REQ-015 STATUS SHALL be read-only: [1:0] current digit index, [2] busy (state not IDLE); writes to address 3 SHALL be ignored.
REQ-016 The prescale counter SHALL load PRESCALE in IDLE, count down by 1 per clock otherwise, and assert a one-clock tick when it reaches 0 while reloading PRESCALE in that cycle.
REQ-017 FSM states SHALL be IDLE, DRIVE, BLANK.
REQ-018 IDLE -> DRIVE on the clock after enable=1, with digit index 0.
REQ-019 DRIVE -> BLANK on tick; BLANK SHALL last exactly one clock, then -> DRIVE with digit index incremented modulo 4 (3 wraps to 0).
REQ-020 Any state -> IDLE on the clock after enable=0; digit index SHALL reset to 0.
REQ-021 In DRIVE, dig_n SHALL drive only the current digit low, unless that digit's blank mask bit is 1, in which case dig_n SHALL be 4'hF.
REQ-022 In IDLE and BLANK, dig_n SHALL be 4'hF, seg_n 7'h7F, and dp_n 1.
REQ-023 In DRIVE, seg_n SHALL be the standard hex decode of the current nibble (0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E), and dp_n SHALL be the inverse of the digit's CTRL dp bit.
REQ-024 seg_n, dp_n, and dig_n SHALL be registered, reflecting state, DATA, and CTRL one clock after they change.
REQ-025 A register write SHALL be visible on readdata the clock after the write cycle.
REQ-026 A DATA write during DRIVE SHALL update the displayed pattern without disturbing the counter or the digit index.

Reset
REQ-027 On reset: DATA=0, CTRL=0, PRESCALE=PRESCALE_INIT, counter=PRESCALE_INIT, FSM=IDLE, digit index=0.
REQ-028 During reset: seg_n=7'h7F, dp_n=1, dig_n=4'hF.
REQ-029 Reset asserted mid-scan SHALL return all state to REQ-027 values immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro SEG7_GHOST_BLANK_EN SHALL control the BLANK state.
REQ-031 With SEG7_GHOST_BLANK_EN defined, REQ-019 applies.
REQ-032 Without SEG7_GHOST_BLANK_EN, BLANK SHALL not exist; a tick in DRIVE SHALL advance the digit index directly, staying in DRIVE, giving exactly PRESCALE+1 clocks per digit.

Verification
REQ-033 Reset release -> readdata at address 2 = 999, dig_n=4'hF, seg_n=7'h7F, STATUS=0.
REQ-034 PRESCALE=3, DATA=16'h8A10, CTRL=1 -> digits 0,1,2,3 in sequence showing seg_n 7'h40, 7'h79, 7'h08, 7'h00; BLANK present -> 4 clocks per digit plus a 1-clock all-off gap.
REQ-035 Scan running, write CTRL=0 -> dig_n=4'hF within 2 clocks; STATUS=0.
REQ-036 CTRL=16'h0241 (enable, dp digit 2, blank digit 1) -> digit 1 slot has dig_n=4'hF; digit 2 shows dp_n=0.
REQ-037 Write PRESCALE=1 mid-period with old value 7 -> current period completes at 8 clocks; subsequent periods are 2 clocks.
REQ-038 Assert reset during DRIVE on digit 3 -> outputs go off asynchronously; DATA reads 0 after release.

Source files
------------

// File: rtl/nios_sys_seg7_scan_if.sv
// nios_sys_seg7_scan_if: Avalon-MM slave bus for the 7-segment scanner
interface nios_sys_seg7_scan_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_sys_seg7_scan.sv
// nios_sys_seg7_scan: 4-digit multiplexed hex 7-segment scanner; SEG7_GHOST_BLANK_EN adds a one-clock all-off BLANK between digits
module nios_sys_seg7_scan #(
  parameter logic [15:0] PRESCALE_INIT = 16'd999
) (
  input  logic                        clk,
  input  logic                        reset,
  nios_sys_seg7_scan_if.slave         bus,
  output logic [6:0]                  seg_n,
  output logic                        dp_n,
  output logic [3:0]                  dig_n
);
`ifdef SEG7_GHOST_BLANK_EN
  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [11:0] ctrl_q, ctrl_d;
  logic [15:0] pre_q, pre_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  dig_q, dig_d;
  logic        wr, tick, en, drive, unused_wd;
  logic [3:0]  nib;
  assign wr        = bus.chipselect & ~bus.write_n;
  assign en        = ctrl_q[0];
  assign tick      = state_q == DRIVE && cnt_q == 16'd0;
  assign drive     = state_q == DRIVE;
  assign nib       = data_q[{idx_q, 2'b00} +: 4];
  assign unused_wd = ^bus.writedata[31:16];
  assign bus.readdata = bus.address == 2'd0 ? {16'b0, data_q} :
                        bus.address == 2'd1 ? {20'b0, ctrl_q} :
                        bus.address == 2'd2 ? {16'b0, pre_q}  :
                                              {29'b0, state_q != IDLE, idx_q};
  assign seg_n = seg_q;
  assign dp_n  = dp_q;
  assign dig_n = dig_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Register writes and prescale counter; counter reloads whenever not driving so the next DRIVE gets a full period
  always_comb begin
    data_d = wr && bus.address == 2'd0 ? bus.writedata[15:0] : data_q;
    ctrl_d = wr && bus.address == 2'd1 ? bus.writedata[11:0] & 12'hFF1 : ctrl_q;
    pre_d  = wr && bus.address == 2'd2 ? bus.writedata[15:0] : pre_q;
    cnt_d  = !drive || tick ? pre_q : cnt_q - 16'd1;
  end

  // Scan FSM next state and digit index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DRIVE;
          idx_d   = 2'd0;
        end
`ifdef SEG7_GHOST_BLANK_EN
        DRIVE: state_d = tick ? BLANK : DRIVE;
        BLANK: begin
          state_d = DRIVE;
          idx_d   = idx_q + 2'd1;
        end
`else
        DRIVE: idx_d = tick ? idx_q + 2'd1 : idx_q;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Display pattern for the current state; registered below so pins are glitch-free
  always_comb begin
    seg_d = drive ? hex7(nib) : 7'h7F;
    dp_d  = ~(drive & ctrl_q[4 + idx_q]);
    dig_d = drive && !ctrl_q[8 + idx_q] ? ~(4'b0001 << idx_q) : 4'hF;
  end

  // All state, with asynchronous reset to the idle/blank display
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= PRESCALE_INIT;
      data_q  <= 16'd0;
      ctrl_q  <= 12'd0;
      pre_q   <= PRESCALE_INIT;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      dig_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      pre_q   <= pre_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
    end
  end
endmodule

// File: tb/tb_nios_sys_seg7_scan.sv
// tb_nios_sys_seg7_scan: register table, directed scan sequences and random traffic against a slot-arithmetic display model
module tb_nios_sys_seg7_scan;
`ifdef SEG7_GHOST_BLANK_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] SCAN_SEG [4] = '{7'h40, 7'h79, 7'h08, 7'h00};
  typedef struct {
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] seg_n;
  logic dp_n;
  logic [3:0] dig_n;
  int checks = 0;
  int errors = 0;
  bit chk_model = 1'b1;
  logic [15:0] m_data, m_pre;
  logic [11:0] m_ctrl;
  int m_pos, m_len;
  vec_t tbl[7];

  nios_sys_seg7_scan_if bus();
  nios_sys_seg7_scan dut (.clk(clk), .reset(reset), .bus(bus), .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_rst();
    m_data = 16'd0;
    m_ctrl = 12'd0;
    m_pre  = 16'd999;
    m_pos  = -1;
    m_len  = 1;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {16'b0, m_data};
      2'd1: return {20'b0, m_ctrl};
      2'd2: return {16'b0, m_pre};
      default: return m_pos < 0 ? 32'd0 : {29'b0, 1'b1, 2'((m_pos / m_len) % 4)};
    endcase
  endfunction

  function automatic logic [11:0] m_disp();
    int d;
    if (m_pos < 0 || m_pos % m_len >= m_len - G) return {7'h7F, 1'b1, 4'hF};
    d = (m_pos / m_len) % 4;
    return {HEX[m_data[d*4 +: 4]], ~m_ctrl[4+d], m_ctrl[8+d] ? 4'hF : 4'(~(1 << d))};
  endfunction

  task automatic cycle(input bit wr, input logic [1:0] a, input logic [31:0] wd);
    logic [11:0] exp;
    int np;
    bus.chipselect = wr;
    bus.write_n    = wr ? 1'b0 : 1'($urandom_range(0, 1));
    bus.address    = a;
    bus.writedata  = wd;
    #1;
    if (!wr && chk_model) chk("rd_model", bus.readdata, m_read(a));
    exp = m_disp();
    np = !m_ctrl[0] ? -1 : (m_pos < 0 ? 0 : m_pos + 1);
    if (m_pos < 0 && np == 0) m_len = int'(m_pre) + 1 + G;
    @(posedge clk);
    m_pos = np;
    if (wr) begin
      case (a)
        2'd0: m_data = wd[15:0];
        2'd1: m_ctrl = wd[11:0] & 12'hFF1;
        2'd2: m_pre  = wd[15:0];
        default: ;
      endcase
    end
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    if (chk_model) chk("disp_model", {20'b0, seg_n, dp_n, dig_n}, {20'b0, exp});
  endtask

  task automatic wait_dig(input logic [3:0] v, input int max);
    int n = 0;
    while (dig_n !== v && n < max) begin
      cycle(1'b0, 2'd0, 32'd0);
      n++;
    end
    chk("wait_dig", {28'b0, dig_n}, {28'b0, v});
  endtask

  task automatic run_len(input logic [3:0] v, output int n);
    n = 0;
    while (dig_n === v && n < 20) begin
      n++;
      cycle(1'b0, 2'd0, 32'd0);
    end
  endtask

  initial begin
    int n, d1, dp2;
    tbl[0] = '{2'd0, 32'hFFFF_1234, 32'h0000_1234};
    tbl[1] = '{2'd1, 32'hFFFF_FFFE, 32'h0000_0FF0};
    tbl[2] = '{2'd2, 32'hABCD_0005, 32'h0000_0005};
    tbl[3] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[4] = '{2'd0, 32'h0000_BEEF, 32'h0000_BEEF};
    tbl[5] = '{2'd1, 32'h0000_000E, 32'h0000_0000};
    tbl[6] = '{2'd2, 32'h0001_0003, 32'h0000_0003};
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
    m_rst();
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'b0, seg_n}, 32'h7F);
    chk("rst_dp", {31'b0, dp_n}, 32'h1);
    chk("rst_dig", {28'b0, dig_n}, 32'hF);
    reset = 1'b0;
    @(negedge clk);
    bus.address = 2'd2;
    #1 chk("init_prescale", bus.readdata, 32'd999);
    bus.address = 2'd3;
    #1 chk("init_status", bus.readdata, 32'd0);
    chk("init_dig", {28'b0, dig_n}, 32'hF);
    chk("init_seg", {25'b0, seg_n}, 32'h7F);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, tbl[i].a, tbl[i].wd);
      bus.address = tbl[i].a;
      #1 chk("tbl_rd", bus.readdata, tbl[i].exp);
    end
    cycle(1'b1, 2'd2, 32'd3);
    cycle(1'b1, 2'd0, 32'h8A10);
    cycle(1'b1, 2'd1, 32'd1);
    wait_dig(4'hE, 10);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk("scan_dig", {28'b0, dig_n}, {28'b0, 4'(~(1 << k))});
        chk("scan_seg", {25'b0, seg_n}, {25'b0, SCAN_SEG[k]});
        cycle(1'b0, 2'd0, 32'd0);
      end
      if (G == 1) begin
        chk("scan_gap", {28'b0, dig_n}, 32'hF);
        cycle(1'b0, 2'd0, 32'd0);
      end
    end
    cycle(1'b1, 2'd1, 32'h0241);
    d1 = 0;
    dp2 = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 2'($urandom_range(0, 3)), 32'd0);
      if (dig_n == 4'hD) d1++;
      if (dig_n == 4'hB && dp_n == 1'b0) dp2++;
    end
    chk("blank_dig1", d1, 0);
    chk("dp_dig2_seen", {31'b0, dp2 > 0}, 32'd1);
    cycle(1'b1, 2'd1, 32'd0);
    cycle(1'b0, 2'd0, 32'd0);
    cycle(1'b0, 2'd0, 32'd0);
    chk("stop_dig", {28'b0, dig_n}, 32'hF);
    bus.address = 2'd3;
    #1 chk("stop_status", bus.readdata, 32'd0);
    cycle(1'b1, 2'd2, 32'd2);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) cycle(1'b1, 2'd0, $urandom);
      else if (r == 2) cycle(1'b1, 2'd1, ($urandom & 32'hFFFF_FFFE) | {31'b0, $urandom_range(0, 5) != 0});
      else if (r == 3 && !m_ctrl[0] && m_pos < 0) cycle(1'b1, 2'd2, $urandom_range(0, 3));
      else if (r == 4) cycle(1'b1, 2'd3, $urandom);
      else cycle(1'b0, 2'($urandom_range(0, 3)), 32'd0);
    end
    cycle(1'b1, 2'd1, 32'd0);
    cycle(1'b0, 2'd0, 32'd0);
    cycle(1'b0, 2'd0, 32'd0);
    chk_model = 1'b0;
    cycle(1'b1, 2'd2, 32'd7);
    cycle(1'b1, 2'd0, 32'h8A10);
    cycle(1'b1, 2'd1, 32'd1);
    wait_dig(4'hE, 10);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (n == 3) cycle(1'b1, 2'd2, 32'd1);
      else cycle(1'b0, 2'd0, 32'd0);
      if (dig_n == 4'hE) n++;
      else break;
    end
    chk("period_old", n, 8);
    if (G == 1) begin
      chk("period_gap", {28'b0, dig_n}, 32'hF);
      cycle(1'b0, 2'd0, 32'd0);
    end
    run_len(4'hD, n);
    chk("period_new1", n, 2);
    if (G == 1) cycle(1'b0, 2'd0, 32'd0);
    run_len(4'hB, n);
    chk("period_new2", n, 2);
    cycle(1'b1, 2'd1, 32'd0);
    cycle(1'b0, 2'd0, 32'd0);
    cycle(1'b0, 2'd0, 32'd0);
    chk_model = 1'b1;
    cycle(1'b1, 2'd2, 32'd2);
    cycle(1'b1, 2'd1, 32'd1);
    wait_dig(4'h7, 40);
    reset = 1'b1;
    #1;
    chk("async_dig", {28'b0, dig_n}, 32'hF);
    chk("async_seg", {25'b0, seg_n}, 32'h7F);
    chk("async_dp", {31'b0, dp_n}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    m_rst();
    bus.address = 2'd0;
    #1 chk("post_rst_data", bus.readdata, 32'd0);
    bus.address = 2'd3;
    #1 chk("post_rst_status", bus.readdata, 32'd0);
    repeat (4) cycle(1'b0, 2'($urandom_range(0, 3)), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
